// File: rtl/led_matrix_capture.sv
// Purpose: captures red/green LED frames by watching a scanned 8x8 matrix bus and locking onto its row sequence.
// Latency: with HOLD_CYCLES=1, pins sampled at edge E0 are written at edge E1; frame_valid is high in the cycle after E1.
// Backpressure: none; this is a passive bus snooper and always samples the bus.
// Ports: clk/reset (sync, active-high); row_sink (active-low one-hot), red_driver, green_driver (column data);
//        red_frame/green_frame (last full frame, index = row), frame_valid (1-cycle pulse),
//        sync_lost (high while hunting for row 0), error_count (saturating sequence/pattern error count).
module led_matrix_capture #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      row_sink,
  input  logic [7:0]      red_driver,
  input  logic [7:0]      green_driver,
  output logic [7:0][7:0] red_frame,
  output logic [7:0][7:0] green_frame,
  output logic            frame_valid,
  output logic            sync_lost,
  output logic [7:0]      error_count
);

  localparam logic [3:0] HOLD = 4'(HOLD_CYCLES);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t          state;
  logic [7:0]      row_q, red_q, green_q, row_prev;
  logic [3:0]      stab_q, stab_cur, zero_cnt;
  logic [2:0]      row_idx, expected;
  logic [7:0][7:0] red_back, green_back;
  logic            at_thresh, accept, bad_hit, in_seq, err_event;

  // Decode the registered row select: number of low bits and position of the low bit.
  always_comb begin
    zero_cnt = 4'd0;
    row_idx  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!row_q[i]) begin
        zero_cnt = zero_cnt + 4'd1;
        row_idx  = 3'(i);
      end
    end
  end

  // stab_q holds the run length of row_prev; stab_cur is the run length of row_q.
  // Acceptance fires only when the run length equals HOLD exactly, so once per dwell.
  assign stab_cur  = (row_q != row_prev) ? 4'd1 :
                     ((stab_q == 4'd15) ? 4'd15 : stab_q + 4'd1);
  assign at_thresh = (stab_cur == HOLD);
  assign accept    = at_thresh && (zero_cnt == 4'd1);
  assign bad_hit   = at_thresh && (zero_cnt >= 4'd2);
  assign in_seq    = (state == LOCK) && (row_idx == expected);
  assign err_event = bad_hit || (accept && (state == LOCK) && !in_seq);

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q       <= 8'hFF;
      red_q       <= 8'h00;
      green_q     <= 8'h00;
      row_prev    <= 8'hFF;
      stab_q      <= 4'd1;
      state       <= HUNT;
      expected    <= 3'd0;
      red_back    <= '0;
      green_back  <= '0;
      red_frame   <= '0;
      green_frame <= '0;
      frame_valid <= 1'b0;
      sync_lost   <= 1'b1;
      error_count <= 8'h00;
    end else begin
      row_q       <= row_sink;
      red_q       <= red_driver;
      green_q     <= green_driver;
      row_prev    <= row_q;
      stab_q      <= stab_cur;
      frame_valid <= 1'b0;

      if (err_event && (error_count != 8'hFF))
        error_count <= error_count + 8'd1;

      if (accept && in_seq) begin
        red_back[row_idx]   <= red_q;
        green_back[row_idx] <= green_q;
        expected            <= expected + 3'd1;
        if (row_idx == 3'd7) begin
          // Publish the back buffer with row 7 taken straight from the input stage,
          // since its back-buffer write lands on this same edge.
          for (int r = 0; r < 7; r++) begin
            red_frame[r]   <= red_back[r];
            green_frame[r] <= green_back[r];
          end
          red_frame[7]   <= red_q;
          green_frame[7] <= green_q;
          frame_valid    <= 1'b1;
        end
      end else if (accept) begin
        if (state == LOCK) begin
          state     <= HUNT;
          sync_lost <= 1'b1;
        end
        // Row 0 always restarts a frame, even straight out of a sequence error.
        if (row_idx == 3'd0) begin
          red_back[0]   <= red_q;
          green_back[0] <= green_q;
          expected      <= 3'd1;
          state         <= LOCK;
          sync_lost     <= 1'b0;
        end
      end else if (bad_hit) begin
        state     <= HUNT;
        sync_lost <= 1'b1;
      end
    end
  end

endmodule

// File: doc/led_matrix_capture.md
LED_MATRIX_CAPTURE -- requirements
Module: led_matrix_capture

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 1, meaning consecutive identical registered row_sink samples required before a row is accepted (legal range 1..15).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port row_sink  input  8  active-low one-hot row select from the scanned matrix bus; bit i low selects row i.
REQ-005 SHALL have port red_driver  input  8  red column data for the selected row.
REQ-006 SHALL have port green_driver  input  8  green column data for the selected row.
REQ-007 SHALL have port red_frame  output  [7:0][7:0]  last complete captured red frame; index = row.
REQ-008 SHALL have port green_frame  output  [7:0][7:0]  last complete captured green frame.
REQ-009 SHALL have port frame_valid  output  1  one-cycle pulse when red_frame/green_frame update.
REQ-010 SHALL have port sync_lost  output  1  high while the block is not locked to the row sequence.
REQ-011 SHALL have port error_count  output  8  saturating count of sequence/pattern errors.

Function
REQ-012 SHALL register row_sink, red_driver, green_driver in one input stage on every clk; all decoding uses the registered values only.
REQ-013 SHALL classify the registered row_sink as: VALID (exactly one bit 0), IDLE (8'hFF), or BAD (two or more bits 0).
REQ-014 SHALL keep a 4-bit stability counter: reset to 1 when the registered row_sink differs from its previous registered value, else increment, saturating at 15.
REQ-015 SHALL accept a row exactly once per dwell: in the cycle the stability counter equals HOLD_CYCLES while the pattern is VALID.
REQ-016 SHALL write accepted row data into an internal back buffer at index = position of the 0 bit, using the registered driver values of the accepting cycle.
REQ-017 SHALL implement states HUNT and LOCK with a 3-bit expected-row counter.
REQ-018 In HUNT, SHALL ignore accepted rows 1..7; an accepted row 0 SHALL be written, expected set to 1, state to LOCK.
REQ-019 In LOCK, an accepted row equal to expected SHALL be written and expected incremented modulo 8 (7 wraps to 0).
REQ-020 In LOCK, an accepted row not equal to expected SHALL increment error_count and enter HUNT; if that row is 0 it SHALL instead be handled as in REQ-018 (write, expected 1, LOCK) after counting the error.
REQ-021 A BAD pattern reaching the stability threshold SHALL increment error_count and force HUNT in either state; IDLE SHALL be ignored with no state change.
REQ-022 On acceptance of row 7 in LOCK, SHALL copy the back buffer (including row 7 data) to red_frame/green_frame at the same edge and drive frame_valid high for the following cycle only.
REQ-023 Latency: with HOLD_CYCLES=1, data presented at the pins before edge E0 SHALL be written at edge E1; frame_valid for row 7 SHALL be high in the cycle after E1.
REQ-024 Partial frames SHALL never reach red_frame/green_frame; the outputs change only per REQ-022.
REQ-025 sync_lost SHALL equal 1 in HUNT and 0 in LOCK, registered with state.
REQ-026 error_count SHALL saturate at 8'hFF and never wrap.

Reset
REQ-027 While reset is high at a clk edge: state HUNT, expected 0, stability counter 1, input stage row_sink 8'hFF and drivers 8'h00, back buffer and red_frame/green_frame all 0, frame_valid 0, sync_lost 1, error_count 0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame and clear outputs per REQ-027; capture resumes at the next accepted row 0.

Verification
REQ-029 Loopback with the matrix scan driver (HOLD_CYCLES=1), red row i = 8'h01<<i, green row i = ~(8'h01<<i), reset released with count at 0 -> first frame_valid 9 cycles after release, frames match inputs, then one pulse every 8 cycles, sync_lost 0, error_count 0.
REQ-030 Sequence 0,1,2,4 -> error_count 1, sync_lost 1, frames unchanged; following 0..7 -> lock, frame_valid once.
REQ-031 row_sink 8'hFC held 1 cycle in LOCK -> error_count +1, HUNT; row_sink 8'hFF held 5 cycles -> no change.
REQ-032 HOLD_CYCLES=3, each row held 2 cycles -> no acceptance, no frame_valid; each row held 4 cycles -> single accept per row, frame_valid every 32 cycles.
REQ-033 Reset asserted after rows 0..4 -> all outputs at reset values; 300 forced errors -> error_count 8'hFF.
